// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes I/S/B/U/J/shift-amount immediates,
// extends them to XLEN, and queues {immediate, fmt, tag} in a 2-entry output FIFO.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instruction_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  immediate_o,
  output logic [2:0]       fmt_o,
  output logic [TAG_W-1:0] tag_o
);
  localparam logic [2:0] FMT_I = 3'd0, FMT_S = 3'd1, FMT_B = 3'd2, FMT_U = 3'd3,
                         FMT_J = 3'd4, FMT_SHAMT = 3'd5, FMT_NONE = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [31:0]     ins;
  logic [31:0]     raw;
  logic [2:0]      dec_fmt;
  logic            is_sh;
  logic [XLEN-1:0] dec_imm;

  assign ins = instruction_i;

  // Every format is first assembled as a 32-bit value whose bit 31 equals
  // instruction bit 31 (or 0 for shamt), then widened uniformly to XLEN.
  always_comb begin
    raw     = '0;
    dec_fmt = FMT_NONE;
    is_sh   = (ins[14:12] == 3'b001) || (ins[14:12] == 3'b101);
    case (ins[6:0])
      7'b0010011: begin
        if (is_sh) begin
          dec_fmt = FMT_SHAMT;
          raw     = {26'b0, (XLEN == 64) ? ins[25] : 1'b0, ins[24:20]};
        end else begin
          dec_fmt = FMT_I;
          raw     = {{20{ins[31]}}, ins[31:20]};
        end
      end
      7'b0000011, 7'b1100111: begin
        dec_fmt = FMT_I;
        raw     = {{20{ins[31]}}, ins[31:20]};
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          if (is_sh) begin
            dec_fmt = FMT_SHAMT;
            raw     = {27'b0, ins[24:20]};
          end else begin
            dec_fmt = FMT_I;
            raw     = {{20{ins[31]}}, ins[31:20]};
          end
        end
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        raw     = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        raw     = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        raw     = {ins[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        raw     = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: ;
    endcase
    dec_imm       = {XLEN{raw[31]}};
    dec_imm[31:0] = raw;
  end

  entry_t     mem_q [2];
  entry_t     head;
  logic       rd_q, rd_d, wr_q, wr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push, pop;

  assign in_ready_o  = (cnt_q != 2'd2) & ~rst_i;
  assign out_valid_o = (cnt_q != 2'd0) & ~rst_i;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = 1'b0;
      wr_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (push) wr_d = ~wr_q;
      if (pop)  rd_d = ~rd_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only observable through cnt_q.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem_q[wr_q] <= '{imm: dec_imm, fmt: dec_fmt, tag: tag_i};
  end

  assign head        = mem_q[rd_q];
  assign immediate_o = out_valid_o ? head.imm : '0;
  assign fmt_o       = out_valid_o ? head.fmt : FMT_NONE;
  assign tag_o       = out_valid_o ? head.tag : '0;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table on XLEN=64 and XLEN=32 instances,
// then hand-written backpressure, streaming, flush and reset sequences.
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [7:0]  tag;
  logic        in_ready, out_valid, in_ready32, out_valid32;
  logic [63:0] imm;
  logic [31:0] imm32;
  logic [2:0]  fmt, fmt32;
  logic [7:0]  tag_out, tag_out32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instruction_i(instr), .tag_i(tag), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .immediate_o(imm), .fmt_o(fmt), .tag_o(tag_out));

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready32),
    .instruction_i(instr), .tag_i(tag), .out_valid_o(out_valid32), .out_ready_i(out_ready),
    .immediate_o(imm32), .fmt_o(fmt32), .tag_o(tag_out32));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
  } vec_t;

  vec_t vt[14];
  logic [7:0] exp_tags[3];
  int n;
  bit pushed3;

  initial begin
    vt[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 32'hFFFF_FFFF, 3'd0}; // addi -1
    vt[1]  = '{32'h03F09093, 64'h3F,                  3'd5, 32'h1F,        3'd5}; // slli 63
    vt[2]  = '{32'h43F0D093, 64'h3F,                  3'd5, 32'h1F,        3'd5}; // srai 63
    vt[3]  = '{32'h01F09093, 64'h1F,                  3'd5, 32'h1F,        3'd5}; // slli 31
    vt[4]  = '{32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 32'hFFFF_FFFC, 3'd1}; // sw -4
    vt[5]  = '{32'hFFDFF06F, 64'hFFFF_FFFF_FFFF_FFFC, 3'd4, 32'hFFFF_FFFC, 3'd4}; // jal -4
    vt[6]  = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd3, 32'h8000_0000, 3'd3}; // lui
    vt[7]  = '{32'h002080B3, 64'h0,                   3'd7, 32'h0,         3'd7}; // add
    vt[8]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 32'hFFFF_FFFC, 3'd2}; // beq -4
    vt[9]  = '{32'h01F0909B, 64'h1F,                  3'd5, 32'h0,         3'd7}; // slliw
    vt[10] = '{32'hFFF0009B, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 32'h0,         3'd7}; // addiw -1
    vt[11] = '{32'hFF802083, 64'hFFFF_FFFF_FFFF_FFF8, 3'd0, 32'hFFFF_FFF8, 3'd0}; // lw -8
    vt[12] = '{32'h12345097, 64'h1234_5000,           3'd3, 32'h1234_5000, 3'd3}; // auipc
    vt[13] = '{32'h7FF08067, 64'h7FF,                 3'd0, 32'h7FF,       3'd0}; // jalr 2047

    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; instr = 32'hFFF00093; tag = 8'hAA;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_imm",       imm,            64'd0);
    chk("rst_fmt",       64'(fmt),       64'd7);
    chk("rst_tag",       64'(tag_out),   64'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Decode table: one push, check the next cycle, then let it drain.
    for (int i = 0; i < 14; i++) begin
      instr = vt[i].ins; tag = 8'(i + 8'h40); in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_imm64", i), imm, vt[i].imm64);
      chk($sformatf("v%0d_fmt64", i), 64'(fmt), 64'(vt[i].fmt64));
      chk($sformatf("v%0d_tag", i),   64'(tag_out), 64'(i + 8'h40));
      chk($sformatf("v%0d_imm32", i), 64'(imm32), 64'(vt[i].imm32));
      chk($sformatf("v%0d_fmt32", i), 64'(fmt32), 64'(vt[i].fmt32));
      @(negedge clk);
      chk($sformatf("v%0d_drained", i), 64'(out_valid), 64'd0);
    end

    // Backpressure: three back-to-back pushes into a 2-deep buffer.
    instr = 32'hFFF00093; out_ready = 1'b0; in_valid = 1'b1; tag = 8'd1;
    @(negedge clk); tag = 8'd2;
    @(negedge clk); tag = 8'd3;
    chk("bp_full_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head_tag", 64'(tag_out), 64'd1);
    @(negedge clk);
    chk("bp_still_full", 64'(in_ready), 64'd0);
    chk("bp_hold_tag", 64'(tag_out), 64'd1);
    chk("bp_hold_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("bp_hold_fmt", 64'(fmt), 64'd0);
    out_ready = 1'b1;
    exp_tags[0] = 8'd1; exp_tags[1] = 8'd2; exp_tags[2] = 8'd3;
    n = 0; pushed3 = 1'b0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      if (in_valid && in_ready) pushed3 = 1'b1;
      if (out_valid && out_ready) begin
        chk($sformatf("bp_order%0d", n), 64'(tag_out), 64'(exp_tags[n]));
        n++;
      end
      @(negedge clk);
      if (pushed3) in_valid = 1'b0;
    end
    chk("bp_pop_count", 64'(n), 64'd3);
    chk("bp_no_dup", 64'(out_valid), 64'd0);

    // Streaming at count=1: push and pop every cycle.
    out_ready = 1'b0; in_valid = 1'b1; tag = 8'h10; instr = 32'h03F09093;
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tag = 8'(8'h11 + k);
      chk($sformatf("st%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("st%0d_ready", k), 64'(in_ready), 64'd1);
      chk($sformatf("st%0d_tag", k), 64'(tag_out), 64'(8'h10 + k));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("st_last_tag", 64'(tag_out), 64'h1A);
    chk("st_last_imm", imm, 64'h3F);
    @(negedge clk);
    chk("st_empty", 64'(out_valid), 64'd0);

    // Flush with a full buffer and a concurrent push.
    out_ready = 1'b0; in_valid = 1'b1; tag = 8'h55;
    repeat (2) @(negedge clk);
    chk("fl_pre_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_fmt", 64'(fmt), 64'd7);
    @(negedge clk);
    chk("fl_discard", 64'(out_valid), 64'd0);

    // Reset with a full buffer, concurrent push and flush.
    in_valid = 1'b1; tag = 8'h66;
    repeat (2) @(negedge clk);
    chk("rs_pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("rs_valid", 64'(out_valid), 64'd0);
    chk("rs_in_ready", 64'(in_ready), 64'd0);
    chk("rs_imm", imm, 64'd0);
    chk("rs_fmt", 64'(fmt), 64'd7);
    chk("rs_tag", 64'(tag_out), 64'd0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rs_after_valid", 64'(out_valid), 64'd0);
    chk("rs_after_ready", 64'(in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
